bsg_manycore_link_to_axil_rx_arb: RTL



---
 rtl/bsg_manycore_link_to_axil_rx_arb_if.sv | 34 +++
 rtl/bsg_manycore_link_to_axil_rx_arb.sv | 136 +++++++++++++
 2 files changed

// File: rtl/bsg_manycore_link_to_axil_rx_arb_if.sv
// Bundle of the arbiter's channel, downstream and counter signals.
// The arbiter sits on the slave side; the upstream buffers and the
// AXI-Lite read mux together form the master side.
interface bsg_manycore_link_to_axil_rx_arb_if #(
    parameter int width_p     = 32,
    parameter int cnt_width_p = 16
);
    logic [width_p-1:0]     ch0_data_i;
    logic                   ch0_v_i;
    logic                   ch0_yumi_o;
    logic [width_p-1:0]     ch1_data_i;
    logic                   ch1_v_i;
    logic                   ch1_yumi_o;
    logic [width_p-1:0]     data_o;
    logic                   v_o;
    logic                   ready_i;
    logic                   ch_o;
    logic                   last_o;
    logic                   busy_o;
    logic [cnt_width_p-1:0] ch0_pkt_cnt_o;
    logic [cnt_width_p-1:0] ch1_pkt_cnt_o;

    modport slave (
        input  ch0_data_i, ch0_v_i, ch1_data_i, ch1_v_i, ready_i,
        output ch0_yumi_o, ch1_yumi_o, data_o, v_o, ch_o, last_o, busy_o,
               ch0_pkt_cnt_o, ch1_pkt_cnt_o
    );

    modport master (
        output ch0_data_i, ch0_v_i, ch1_data_i, ch1_v_i, ready_i,
        input  ch0_yumi_o, ch1_yumi_o, data_o, v_o, ch_o, last_o, busy_o,
               ch0_pkt_cnt_o, ch1_pkt_cnt_o
    );
endinterface

// File: rtl/bsg_manycore_link_to_axil_rx_arb.sv
// Packet-atomic round-robin arbiter: two rx channels (0 = requests,
// 1 = responses) share one AXI-Lite read-data path. Once a channel wins
// the first beat of a packet it owns the output until the last beat.
// Data is passed through combinationally; nothing is buffered here.
// Optional per-channel packet counters are enabled by defining
// BSG_MANYCORE_LINK_TO_AXIL_RX_ARB_PKT_CNT_EN; otherwise they read 0.
module bsg_manycore_link_to_axil_rx_arb #(
    parameter int width_p     = 32,
    parameter int els_p       = 4,
    parameter int cnt_width_p = 16
) (
    input  logic clk_i,
    input  logic reset_n_i,
    bsg_manycore_link_to_axil_rx_arb_if.slave link
);

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_e;

    localparam int cnt_w_lp = $clog2(els_p + 1);
    localparam logic [cnt_w_lp-1:0] last_beat_lp = cnt_w_lp'(els_p - 1);

    state_e              state_r, state_n;
    logic                grant_r, grant_n;
    logic                last_grant_r, last_grant_n;
    logic [cnt_w_lp-1:0] beat_cnt_r, beat_cnt_n;

    logic               sel;
    logic               sel_v;
    logic [width_p-1:0] sel_data;
    logic               v;
    logic               xfer;
    logic               last;

    // Pick the channel driving the output: locked owner, else round-robin
    always_comb begin
        sel = last_grant_r;
        if (state_r == LOCK) begin
            sel = grant_r;
        end else if (link.ch0_v_i && link.ch1_v_i) begin
            sel = ~last_grant_r;
        end else if (link.ch0_v_i) begin
            sel = 1'b0;
        end else if (link.ch1_v_i) begin
            sel = 1'b1;
        end
    end

    // Valid is gated by reset so nothing leaks out while reset is held
    assign sel_v    = sel ? link.ch1_v_i : link.ch0_v_i;
    assign sel_data = sel ? link.ch1_data_i : link.ch0_data_i;
    assign v        = sel_v & reset_n_i;
    assign xfer     = v & link.ready_i;
    assign last     = v & (beat_cnt_r == last_beat_lp);

    assign link.data_o     = sel_data;
    assign link.v_o        = v;
    assign link.ch_o       = sel;
    assign link.last_o     = last;
    assign link.busy_o     = (state_r == LOCK);
    assign link.ch0_yumi_o = xfer & ~sel;
    assign link.ch1_yumi_o = xfer & sel;

    // Next-state logic: lock on the first beat, release on the last
    always_comb begin
        state_n      = state_r;
        grant_n      = grant_r;
        last_grant_n = last_grant_r;
        beat_cnt_n   = beat_cnt_r;
        if (state_r == IDLE) begin
            if (xfer) begin
                if (els_p == 1) begin
                    last_grant_n = sel;
                end else begin
                    grant_n    = sel;
                    beat_cnt_n = cnt_w_lp'(1);
                    state_n    = LOCK;
                end
            end
        end else begin
            if (xfer) begin
                if (beat_cnt_r == last_beat_lp) begin
                    last_grant_n = grant_r;
                    beat_cnt_n   = '0;
                    state_n      = IDLE;
                end else begin
                    beat_cnt_n = beat_cnt_r + cnt_w_lp'(1);
                end
            end
        end
    end

    // State registers; last_grant resets to 1 so channel 0 wins the first tie
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r      <= IDLE;
            grant_r      <= 1'b0;
            last_grant_r <= 1'b1;
            beat_cnt_r   <= '0;
        end else begin
            state_r      <= state_n;
            grant_r      <= grant_n;
            last_grant_r <= last_grant_n;
            beat_cnt_r   <= beat_cnt_n;
        end
    end

`ifdef BSG_MANYCORE_LINK_TO_AXIL_RX_ARB_PKT_CNT_EN
    logic [cnt_width_p-1:0] ch0_cnt_r;
    logic [cnt_width_p-1:0] ch1_cnt_r;

    // Count completed packets per channel; wraps naturally
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ch0_cnt_r <= '0;
            ch1_cnt_r <= '0;
        end else begin
            if (xfer && last && !sel) begin
                ch0_cnt_r <= ch0_cnt_r + cnt_width_p'(1);
            end
            if (xfer && last && sel) begin
                ch1_cnt_r <= ch1_cnt_r + cnt_width_p'(1);
            end
        end
    end

    assign link.ch0_pkt_cnt_o = ch0_cnt_r;
    assign link.ch1_pkt_cnt_o = ch1_cnt_r;
`else
    assign link.ch0_pkt_cnt_o = {cnt_width_p{1'b0}};
    assign link.ch1_pkt_cnt_o = {cnt_width_p{1'b0}};
`endif

endmodule
